// File: rtl/dds_pkg.sv
// dds_pkg: shared widths, FSM states and quarter-wave table math
// for the dds_sincos_gen phase-accumulator source.
package dds_pkg;

    localparam int PHASE_W_DEF = 32;
    localparam int LUT_AW_DEF  = 10;
    localparam int NDATA_DEF   = 12;

    localparam logic [1:0] PRIME_LAST = 2'd2;

    // pi/2 in Q30
    localparam longint HALF_PI_Q30 = 64'sd1686629713;

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        RUN
    } dds_state_e;

    function automatic logic [63:0] quarter(input int w);
        return 64'd1 << (w - 2);
    endfunction

    localparam logic [PHASE_W_DEF-1:0] QUARTER =
        PHASE_W_DEF'(quarter(PHASE_W_DEF));

    // round((2^(nd-1)-1) * sin(pi/2 * k / 2^aw)) via Q30 Taylor series
    function automatic int rom_entry(input int k, input int aw,
                                     input int nd);
        longint x;
        longint term;
        longint sum;
        longint amp;
        longint r;
        x    = (HALF_PI_Q30 * longint'(k)) >>> aw;
        term = x;
        sum  = x;
        for (int n = 1; n <= 10; n++) begin
            term = (term * x) >>> 30;
            term = (term * x) >>> 30;
            term = -term / longint'((2 * n) * (2 * n + 1));
            sum  = sum + term;
        end
        amp = (longint'(1) <<< (nd - 1)) - 1;
        r   = (sum * amp + (longint'(1) <<< 29)) >>> 30;
        if (r < 0) begin
            r = 0;
        end
        if (r > amp) begin
            r = amp;
        end
        return int'(r);
    endfunction

endpackage

// File: rtl/dds_qrom.sv
// dds_qrom: synchronous quarter-wave magnitude ROM,
// 2^AW+1 entries so both quadrant end points are stored exactly.
module dds_qrom
    import dds_pkg::*;
#(
    parameter int AW = LUT_AW_DEF,
    parameter int DW = NDATA_DEF - 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW:0]   addr,
    output logic [DW-1:0] data
);

    localparam int DEPTH = (1 << AW) + 1;

    logic [DW-1:0] rom [DEPTH];

    for (genvar k = 0; k < DEPTH; k++) begin : g_rom
        localparam logic [DW-1:0] V = DW'(rom_entry(k, AW, DW + 1));
        assign rom[k] = V;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data <= '0;
        end else begin
            data <= rom[addr];
        end
    end

endmodule

// File: rtl/dds_sincos_gen.sv
// dds_sincos_gen: DDS sine/cosine source, 3-stage pipeline to the DAC stage.
// Define DDS_PHASE_DITHER_EN to add LFSR dither below the ROM index.
module dds_sincos_gen
    import dds_pkg::*;
#(
    parameter int PHASE_W = PHASE_W_DEF,
    parameter int LUT_AW  = LUT_AW_DEF,
    parameter int Ndata   = NDATA_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               cfg_load,
    input  logic [PHASE_W-1:0] cfg_fword,
    input  logic [PHASE_W-1:0] cfg_poff,
    input  logic               cfg_sync,
    output logic               m_axis_data_tvalid,
    output logic [31:0]        m_axis_data_tdata
);

    localparam int SH = PHASE_W - LUT_AW - 2;
    localparam int TW = LUT_AW + 2;
    localparam int MW = Ndata - 1;
    localparam int XW = 16 - Ndata;

    localparam logic [PHASE_W-1:0] QTR = PHASE_W'(quarter(PHASE_W));
    localparam logic [LUT_AW:0]    FULL = (LUT_AW + 1)'(1) << LUT_AW;

    dds_state_e state;
    dds_state_e state_nx;
    logic [1:0] cnt;
    logic [1:0] cnt_nx;

    logic [PHASE_W-1:0] acc;
    logic [PHASE_W-1:0] fword_act;
    logic [PHASE_W-1:0] poff_act;

    logic [PHASE_W-1:0] ps_raw;
    logic [TW-1:0]      ps_top;
    logic [TW-1:0]      pc_top;

    logic [LUT_AW:0] s1_addr_s;
    logic [LUT_AW:0] s1_addr_c;
    logic            s1_neg_s;
    logic            s1_neg_c;

    logic [MW-1:0] mag_s;
    logic [MW-1:0] mag_c;
    logic          s2_neg_s;
    logic          s2_neg_c;

    logic [Ndata-1:0] sin_v;
    logic [Ndata-1:0] cos_v;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        unique case (state)
            IDLE: begin
                if (en) begin
                    state_nx = PRIME;
                    cnt_nx   = '0;
                end
            end
            PRIME: begin
                if (!en) begin
                    state_nx = IDLE;
                end else if (cnt == PRIME_LAST) begin
                    state_nx = RUN;
                end else begin
                    cnt_nx = cnt + 2'd1;
                end
            end
            RUN: begin
                if (!en) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state              <= IDLE;
            cnt                <= '0;
            m_axis_data_tvalid <= 1'b0;
        end else begin
            state              <= state_nx;
            cnt                <= cnt_nx;
            m_axis_data_tvalid <= (state_nx == RUN);
        end
    end

    // Config load leaves acc alone so frequency changes are phase-continuous
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc       <= '0;
            fword_act <= '0;
            poff_act  <= '0;
        end else begin
            if (cfg_load) begin
                fword_act <= cfg_fword;
                poff_act  <= cfg_poff;
            end
            if (cfg_sync) begin
                acc <= '0;
            end else if (state != IDLE) begin
                acc <= acc + fword_act;
            end
        end
    end

`ifdef DDS_PHASE_DITHER_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr <= 16'hACE1;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end
`endif

    always_comb begin
        ps_raw = acc + poff_act;
`ifdef DDS_PHASE_DITHER_EN
        ps_raw = ps_raw + PHASE_W'(lfsr);
`endif
        ps_top = TW'(ps_raw >> SH);
        pc_top = TW'((ps_raw + QTR) >> SH);
    end

    // Odd quadrants walk the table backwards
    function automatic logic [LUT_AW:0] fold(input logic [LUT_AW:0] t);
        logic [LUT_AW:0] idx;
        idx = {1'b0, t[LUT_AW-1:0]};
        return t[LUT_AW] ? FULL - idx : idx;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_addr_s <= '0;
            s1_addr_c <= '0;
            s1_neg_s  <= 1'b0;
            s1_neg_c  <= 1'b0;
            s2_neg_s  <= 1'b0;
            s2_neg_c  <= 1'b0;
        end else begin
            s1_addr_s <= fold(ps_top[LUT_AW:0]);
            s1_addr_c <= fold(pc_top[LUT_AW:0]);
            s1_neg_s  <= ps_top[TW-1];
            s1_neg_c  <= pc_top[TW-1];
            s2_neg_s  <= s1_neg_s;
            s2_neg_c  <= s1_neg_c;
        end
    end

    dds_qrom #(
        .AW (LUT_AW),
        .DW (MW)
    ) u_rom_sin (
        .clk  (clk),
        .rst  (rst),
        .addr (s1_addr_s),
        .data (mag_s)
    );

    dds_qrom #(
        .AW (LUT_AW),
        .DW (MW)
    ) u_rom_cos (
        .clk  (clk),
        .rst  (rst),
        .addr (s1_addr_c),
        .data (mag_c)
    );

    always_comb begin
        sin_v = {1'b0, mag_s};
        cos_v = {1'b0, mag_c};
        if (s2_neg_s) begin
            sin_v = -sin_v;
        end
        if (s2_neg_c) begin
            cos_v = -cos_v;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_axis_data_tdata <= '0;
        end else begin
            m_axis_data_tdata <= {{XW{cos_v[Ndata-1]}}, cos_v,
                                  {XW{sin_v[Ndata-1]}}, sin_v};
        end
    end

endmodule
